keypad_scanner: RTL

//  Scans a 4x4 matrix keypad (Pmod KYPD) and debounces it. Reports one hex key code per press.

---
 rtl/keypad_pkg.sv | 37 +++
 rtl/keypad_if.sv | 18 +
 rtl/keypad_debounce.sv | 91 +++++++++
 rtl/keypad_scanner.sv | 131 +++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner: scan-result encoding,
// key map and the column sequencer states.
package keypad_pkg;

  localparam int NUM_COLS = 4;
  localparam int NUM_ROWS = 4;

  // One full-scan result: present=0 means no single key (KEY_NONE).
  typedef struct packed {
    logic       present;
    logic [3:0] code;
  } keyResult_t;

  localparam keyResult_t KEY_NONE = '{present: 1'b0, code: 4'h0};

  // KEY_MAP[row][col]; row 3 is the top row, col 3 the leftmost column.
  localparam logic [NUM_ROWS-1:0][NUM_COLS-1:0][3:0] KEY_MAP = {
    {4'h1, 4'h2, 4'h3, 4'hA},
    {4'h4, 4'h5, 4'h6, 4'hB},
    {4'h7, 4'h8, 4'h9, 4'hC},
    {4'h0, 4'hF, 4'hE, 4'hD}
  };

  // Encoding equals the column index so a state can drive col_n directly.
  typedef enum logic [1:0] {
    COL0 = 2'd0,
    COL1 = 2'd1,
    COL2 = 2'd2,
    COL3 = 2'd3
  } colState_t;

  function automatic logic [2:0] countOnes(input logic [3:0] v);
    countOnes = 3'd0;
    for (int i = 0; i < 4; i++) countOnes = countOnes + {2'b00, v[i]};
  endfunction

endpackage

// File: rtl/keypad_if.sv
// Keypad pin and key-report bundle; master is the scanner, slave the keypad/display side.
interface keypad_if;
  logic [3:0] row_n;
  logic [3:0] col_n;
  logic [3:0] key_val;
  logic       key_valid;
  logic       key_down;

  modport master (
    input  row_n,
    output col_n, key_val, key_valid, key_down
  );

  modport slave (
    output row_n,
    input  col_n, key_val, key_valid, key_down
  );
endinterface

// File: rtl/keypad_debounce.sv
// Candidate / stable-count / commit logic fed once per full scan.
// Auto-repeat of a held key is built only when KEYPAD_REPEAT_EN is defined.
module keypad_debounce
  import keypad_pkg::*;
#(
  parameter int unsigned DEBOUNCE_SCANS = 4
`ifdef KEYPAD_REPEAT_EN
  ,
  parameter int unsigned REPEAT_SCANS = 50
`endif
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       scanDone,
  input  keyResult_t scanResult,
  output logic [3:0] keyVal,
  output logic       keyValid,
  output logic       keyDown
);

  localparam int unsigned CW = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_SCANS);

  keyResult_t    candidate, candNext, committed;
  logic [CW-1:0] stableCnt, stableNext;
  logic          commit;
  logic          repeatFire;
  logic          pulse;

  // NOTE: every variable gets a default at the top of always_comb so no path leaves it unassigned (no latch).
  always_comb begin
    candNext   = candidate;
    stableNext = stableCnt;
    if (scanResult == candidate) begin
      if (stableCnt != STABLE_MAX) stableNext = stableCnt + 1'b1;
    end else begin
      candNext   = scanResult;
      stableNext = '0;
    end
    commit = scanDone && (stableNext == STABLE_MAX) && (candNext != committed);
  end

  assign pulse = (commit && candNext.present) || repeatFire;

  // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      candidate <= KEY_NONE;
      committed <= KEY_NONE;
      stableCnt <= '0;
      keyVal    <= 4'h0;
      keyValid  <= 1'b0;
      keyDown   <= 1'b0;
    end else begin
      keyValid <= pulse;
      if (scanDone) begin
        candidate <= candNext;
        stableCnt <= stableNext;
      end
      if (commit) begin
        committed <= candNext;
        keyDown   <= candNext.present;
        if (candNext.present) keyVal <= candNext.code;
      end
    end
  end

`ifdef KEYPAD_REPEAT_EN
  localparam int unsigned RW = (REPEAT_SCANS > 1) ? $clog2(REPEAT_SCANS) : 1;
  localparam logic [RW-1:0] REPEAT_LAST = RW'(REPEAT_SCANS - 1);

  logic [RW-1:0] repeatCnt;
  logic          repeatQualify;

  // Counts full scans of the committed key staying held since its last commit.
  assign repeatQualify = scanDone && !commit && keyDown && (scanResult == committed);
  assign repeatFire    = repeatQualify && (repeatCnt == REPEAT_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      repeatCnt <= '0;
    end else if (scanDone) begin
      if (!repeatQualify || repeatFire) repeatCnt <= '0;
      else                              repeatCnt <= repeatCnt + 1'b1;
    end
  end
`else
  assign repeatFire = 1'b0;
`endif

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: row synchronizer, column sequencer and per-scan key encoder,
// followed by keypad_debounce. Define KEYPAD_REPEAT_EN to build auto-repeat.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES  = 100000,
  parameter int unsigned DEBOUNCE_SCANS = 4,
  parameter int unsigned REPEAT_SCANS   = 50
) (
  input logic      clk,
  input logic      rst,
  keypad_if.master kp
);

  if (SETTLE_CYCLES < 1 || DEBOUNCE_SCANS < 1 || REPEAT_SCANS < 1) begin : gBadParams
    $error("keypad_scanner: SETTLE_CYCLES, DEBOUNCE_SCANS and REPEAT_SCANS must be at least 1");
  end

  localparam int unsigned SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

  logic [3:0]    rowMeta, rowSync;
  logic [SW-1:0] settleCnt;
  logic          lastCycle;
  colState_t     colState, colNext;
  logic [3:0]    colN;

  logic [3:0]    rowsLow;
  logic [2:0]    colHits, totalHits;
  logic [1:0]    hitRow;
  logic [1:0]    accCount, baseCount, mergedCount;
  logic [3:0]    accCode, mergedCode;
  keyResult_t    result, scanResult;
  logic          scanDone;

  logic [3:0]    keyVal;
  logic          keyValid, keyDown;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rowMeta <= 4'hF;
      rowSync <= 4'hF;
    end else begin
      rowMeta <= kp.row_n;
      rowSync <= rowMeta;
    end
  end

  assign lastCycle = (settleCnt == SETTLE_LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      settleCnt <= '0;
      colState  <= COL3;
      colN      <= 4'b0111;
    end else begin
      colState <= colNext;
      if (lastCycle) begin
        settleCnt <= '0;
        colN      <= ~(4'b0001 << colNext);
      end else begin
        settleCnt <= settleCnt + 1'b1;
      end
    end
  end

  always_comb begin
    colNext = colState;
    if (lastCycle) begin
      unique case (colState)
        COL3:    colNext = COL2;
        COL2:    colNext = COL1;
        COL1:    colNext = COL0;
        default: colNext = COL3;
      endcase
    end
  end

  // Merge this column's hits into the running scan; counts saturate at 2 (multi-key).
  always_comb begin
    rowsLow = ~rowSync;
    colHits = countOnes(rowsLow);
    hitRow  = 2'd0;
    for (int r = 0; r < NUM_ROWS; r++) begin
      if (rowsLow[r]) hitRow = 2'(r);
    end
    baseCount   = (colState == COL3) ? 2'd0 : accCount;
    totalHits   = {1'b0, baseCount} + colHits;
    mergedCount = (totalHits >= 3'd2) ? 2'd2 : totalHits[1:0];
    mergedCode  = (baseCount == 2'd0) ? KEY_MAP[hitRow][colState] : accCode;
    result      = (mergedCount == 2'd1) ? '{present: 1'b1, code: mergedCode} : KEY_NONE;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      accCount   <= 2'd0;
      accCode    <= 4'h0;
      scanDone   <= 1'b0;
      scanResult <= KEY_NONE;
    end else begin
      scanDone <= lastCycle && (colState == COL0);
      if (lastCycle) begin
        accCount <= mergedCount;
        accCode  <= mergedCode;
        if (colState == COL0) scanResult <= result;
      end
    end
  end

  keypad_debounce #(
    .DEBOUNCE_SCANS(DEBOUNCE_SCANS)
`ifdef KEYPAD_REPEAT_EN
    ,
    .REPEAT_SCANS(REPEAT_SCANS)
`endif
  ) uDebounce (
    .clk       (clk),
    .rst       (rst),
    .scanDone  (scanDone),
    .scanResult(scanResult),
    .keyVal    (keyVal),
    .keyValid  (keyValid),
    .keyDown   (keyDown)
  );

  assign kp.col_n     = colN;
  assign kp.key_val   = keyVal;
  assign kp.key_valid = keyValid;
  assign kp.key_down  = keyDown;

endmodule
